mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the CPU's single-port RAM between instruction fetch (IF) and load/store (LS).
- Sits between the cpu fetch/LSU stages and the RAM instance.
- Uses round-robin arbitration and allows one outstanding transaction.
- Memory read latency is a fixed, parameterised number of cycles; responses are routed back to the owning requester.

Parameters:
ADDR_WIDTH, 31, width of word address to RAM.
DATA_WIDTH, 32, data bus width; byte-enable width is DATA_WIDTH/8.
MEM_LATENCY, 1, cycles from mem_en high to mem_rdata valid; legal range 1..4.

Ports:
clk  in  1  system clock, rising edge.
a_reset  in  1  asynchronous, active-high reset.
if_req  in  1  fetch request; held with if_addr until if_gnt.
if_addr  in  ADDR_WIDTH  fetch word address.
if_gnt  out  1  one-cycle grant pulse to IF.
if_rvalid  out  1  one-cycle read data valid to IF.
if_rdata  out  DATA_WIDTH  fetch read data; 0 when if_rvalid low.
ls_req  in  1  load/store request; held with the ls_* fields until ls_gnt.
ls_we  in  1  1 = store, 0 = load.
ls_be  in  DATA_WIDTH/8  store byte enables.
ls_addr  in  ADDR_WIDTH  LS word address.
ls_wdata  in  DATA_WIDTH  store data.
ls_gnt  out  1  one-cycle grant pulse to LS.
ls_rvalid  out  1  completion pulse; carries load data, acks stores.
ls_rdata  out  DATA_WIDTH  load data; 0 when ls_rvalid low or for stores.
mem_en  out  1  RAM access strobe, one cycle per transaction.
mem_we  out  1  RAM write enable.
mem_be  out  DATA_WIDTH/8  RAM byte enables.
mem_addr  out  ADDR_WIDTH  RAM address.
mem_wdata  out  DATA_WIDTH  RAM write data.
mem_rdata  in  DATA_WIDTH  RAM read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset (async, immediate): state=IDLE, owner=IF, last_grant=IF, latency counter=0. All outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled at the rising edge.
  - Only one requester high: that requester wins.
  - Both high: the requester that is not last_grant wins. Because of the reset value, LS wins the first conflict.
  - With a winner: capture addr, wdata, we, be into registers (IF always we=0, be=all ones); set owner and last_grant; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - Drive mem_en=1 and mem_we/be/addr/wdata from the captured registers.
  - Drive the owner's gnt=1 for this cycle only.
  - Load the counter with MEM_LATENCY-1.
  - Go to RESP if MEM_LATENCY=1, else go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 0. mem_en=0, all gnt/rvalid=0.
- RESP (1 cycle):
  - Owner's rvalid=1.
  - Owner's rdata = mem_rdata for a load; 0 for a store. The non-owner sees rdata=0.
  - Go to IDLE.
- Timing: with a request sampled at edge T, gnt/mem_en are high in cycle T+1 and rvalid is high in cycle T+1+MEM_LATENCY. Minimum issue-to-issue spacing is MEM_LATENCY+2 cycles.
- Requests are ignored outside IDLE.
- A requester deasserts req in the cycle after gnt, or keeps req high to queue its next access.
  - A request still high on return to IDLE is re-arbitrated; the round-robin alternates between two continuous requesters.
- mem_we is high only in the ISSUE cycle of a store. mem_* data/address outputs are held at their last value outside ISSUE; RAM acts on them only with mem_en.
- Reset mid-transaction aborts it: no rvalid for the aborted access, outputs immediately 0, next grant after reset follows the reset last_grant.
- No combinational path from any req input to any output.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, mem_en never high.
- if_req=1, if_addr=0x10 (LATENCY=1), RAM[0x10]=0xDEADBEEF, req dropped after gnt -> if_gnt and mem_en high in cycle 1 with mem_addr=0x10; if_rvalid=1, if_rdata=0xDEADBEEF in cycle 2; one transaction only.
- ls_req store: ls_addr=0x20, ls_wdata=0x12345678, ls_be=0b0011 -> mem_we=1, mem_be=0b0011 in the ISSUE cycle; ls_rvalid pulse with ls_rdata=0; a following load from 0x20 returns 0x00005678 (RAM initialised to 0).
- Both req held high for 6 transactions -> grant order LS, IF, LS, IF, LS, IF; each rvalid goes to the matching owner.
- MEM_LATENCY=3, single IF read -> rvalid exactly 3 cycles after mem_en; next grant no earlier than 5 cycles after the first.
- a_reset asserted in WAIT of an LS load -> outputs 0 immediately, no ls_rvalid; after release with both req high, LS is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port RAM between
// instruction fetch (IF) and load/store (LS), one access in flight.
//
// Ports:
//   clk, a_reset             clock, async active-high reset
//   if_req/if_addr           fetch request (read only)
//   if_gnt/if_rvalid/if_rdata
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata   load/store request
//   ls_gnt/ls_rvalid/ls_rdata
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata   RAM side
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 31,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    a_reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  output logic                    ls_gnt,
  output logic                    ls_rvalid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  // owner/last: 0 = IF, 1 = LS
  logic owner_q;
  logic last_q;
  logic cap;
  logic win_ls;

  logic                  we_q;
  logic [BW-1:0]         be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    win_ls  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          cap     = 1'b1;
          // on conflict the side not granted last time wins
          win_ls  = ls_req && (!if_req || !last_q);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        owner_q <= win_ls;
        last_q  <= win_ls;
        we_q    <= win_ls && ls_we;
        be_q    <= win_ls ? ls_be : '1;
        addr_q  <= win_ls ? ls_addr : if_addr;
        wdata_q <= win_ls ? ls_wdata : '0;
      end
    end
  end

  logic iss;
  logic rsp;

  assign iss = (state_q == ISSUE);
  assign rsp = (state_q == RESP);

  assign mem_en    = iss;
  assign mem_we    = iss && we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_gnt    = iss && !owner_q;
  assign ls_gnt    = iss && owner_q;
  assign if_rvalid = rsp && !owner_q;
  assign ls_rvalid = rsp && owner_q;

  // stores complete with zero data
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign ls_rdata = (ls_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks mem_arbiter at MEM_LATENCY 1 (g[0]) and 3 (g[1])
// against a behavioural RAM and queued expected responses.
module tb_mem_arbiter;

  localparam int AW = 31;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [30:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata  [2];
  logic          ls_req    [2];
  logic          ls_we     [2];
  logic [BW-1:0] ls_be     [2];
  logic [AW-1:0] ls_addr   [2];
  logic [DW-1:0] ls_wdata  [2];
  logic          ls_gnt    [2];
  logic          ls_rvalid [2];
  logic [DW-1:0] ls_rdata  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [BW-1:0] mem_be    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  logic [31:0] exp_if [$];
  logic [31:0] exp_ls [$];
  int gnt_log [$];
  int gnt_time [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = (k == 0) ? 1 : 3;
    logic [31:0] ram [256];
    logic [31:0] pipe [4];
    int t_en;

    mem_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MEM_LATENCY(L)
    ) dut (
      .clk(clk),
      .a_reset(rst[k]),
      .if_req(if_req[k]),
      .if_addr(if_addr[k]),
      .if_gnt(if_gnt[k]),
      .if_rvalid(if_rvalid[k]),
      .if_rdata(if_rdata[k]),
      .ls_req(ls_req[k]),
      .ls_we(ls_we[k]),
      .ls_be(ls_be[k]),
      .ls_addr(ls_addr[k]),
      .ls_wdata(ls_wdata[k]),
      .ls_gnt(ls_gnt[k]),
      .ls_rvalid(ls_rvalid[k]),
      .ls_rdata(ls_rdata[k]),
      .mem_en(mem_en[k]),
      .mem_we(mem_we[k]),
      .mem_be(mem_be[k]),
      .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]),
      .mem_rdata(mem_rdata[k])
    );

    assign mem_rdata[k] = pipe[L-1];

    initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      ram[8'h10] = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
      t_en = 0;
    end

    always @(posedge clk) begin
      for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = mem_en[k] ? ram[mem_addr[k][7:0]] : 32'h0;
      if (mem_en[k] && mem_we[k])
        for (int b = 0; b < 4; b++)
          if (mem_be[k][b])
            ram[mem_addr[k][7:0]][8*b +: 8] = mem_wdata[k][8*b +: 8];
    end

    always @(negedge clk) begin
      if (if_gnt[k] || ls_gnt[k]) begin
        if (if_gnt[k]) chk("dual_gnt", ls_gnt[k], 0);
        chk("mem_en_at_gnt", mem_en[k], 1);
        t_en = cyc;
        gnt_log.push_back(ls_gnt[k] ? 1 : 0);
        gnt_time.push_back(cyc);
      end else if (mem_en[k]) begin
        chk("mem_en_no_gnt", mem_en[k], 0);
      end
      if (mem_we[k] && !mem_en[k]) chk("mem_we_no_en", mem_we[k], 0);
      if (if_rvalid[k]) begin
        chk("if_rvalid_both", ls_rvalid[k], 0);
        chk("if_latency", cyc - t_en, L);
        if (exp_if.size() == 0) chk("if_rvalid_unexpected", if_rvalid[k], 0);
        else chk("if_rdata", if_rdata[k], exp_if.pop_front());
      end else begin
        chk("if_rdata_idle", if_rdata[k], 0);
      end
      if (ls_rvalid[k]) begin
        chk("ls_latency", cyc - t_en, L);
        if (exp_ls.size() == 0) chk("ls_rvalid_unexpected", ls_rvalid[k], 0);
        else chk("ls_rdata", ls_rdata[k], exp_ls.pop_front());
      end else begin
        chk("ls_rdata_idle", ls_rdata[k], 0);
      end
    end
  end

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_if_gnt"}, if_gnt[k], 0);
    chk({tag, "_if_rvalid"}, if_rvalid[k], 0);
    chk({tag, "_if_rdata"}, if_rdata[k], 0);
    chk({tag, "_ls_gnt"}, ls_gnt[k], 0);
    chk({tag, "_ls_rvalid"}, ls_rvalid[k], 0);
    chk({tag, "_ls_rdata"}, ls_rdata[k], 0);
    chk({tag, "_mem_en"}, mem_en[k], 0);
    chk({tag, "_mem_we"}, mem_we[k], 0);
    chk({tag, "_mem_be"}, mem_be[k], 0);
    chk({tag, "_mem_addr"}, mem_addr[k], 0);
    chk({tag, "_mem_wdata"}, mem_wdata[k], 0);
  endtask

  task automatic wait_gnt(input int k, input bit ls, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      n++;
      if (ls ? ls_gnt[k] : if_gnt[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ls ? "ls_gnt_seen" : "if_gnt_seen", ok, 1);
  endtask

  task automatic wait_grants(input int cnt);
    for (int i = 0; i < 80; i++) begin
      if (gnt_log.size() >= cnt) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_if.size() == 0 && exp_ls.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain", exp_if.size() + exp_ls.size(), 0);
    exp_if.delete();
    exp_ls.delete();
  endtask

  task automatic ls_op(input int k, input vec_t v);
    int n;
    bit ok;
    exp_ls.push_back(v.rd);
    ls_req[k]   = 1'b1;
    ls_we[k]    = v.we;
    ls_be[k]    = v.be;
    ls_addr[k]  = v.addr;
    ls_wdata[k] = v.wdata;
    wait_gnt(k, 1'b1, n, ok);
    if (ok) begin
      chk("ls_mem_we", mem_we[k], v.we);
      chk("ls_mem_addr", mem_addr[k], v.addr);
      if (v.we) begin
        chk("ls_mem_be", mem_be[k], v.be);
        chk("ls_mem_wdata", mem_wdata[k], v.wdata);
      end
    end
    ls_req[k] = 1'b0;
    drain();
  endtask

  vec_t tbl [10];

  initial begin
    int n;
    bit ok;
    int rr_exp [6];

    tbl[0] = '{1'b1, 4'b0011, 31'h20, 32'h12345678, 32'h00000000};
    tbl[1] = '{1'b0, 4'b0000, 31'h20, 32'h00000000, 32'h00005678};
    tbl[2] = '{1'b1, 4'b1100, 31'h20, 32'hAABBCCDD, 32'h00000000};
    tbl[3] = '{1'b0, 4'b0000, 31'h20, 32'h00000000, 32'hAABB5678};
    tbl[4] = '{1'b1, 4'b1111, 31'h21, 32'hCAFEF00D, 32'h00000000};
    tbl[5] = '{1'b0, 4'b0000, 31'h21, 32'h00000000, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 4'b0000, 31'h22, 32'h00000000, 32'h00000000};
    tbl[7] = '{1'b1, 4'b0100, 31'h22, 32'hFFFFFFFF, 32'h00000000};
    tbl[8] = '{1'b0, 4'b0000, 31'h22, 32'h00000000, 32'h00FF0000};
    tbl[9] = '{1'b0, 4'b0000, 31'h10, 32'h00000000, 32'hDEADBEEF};
    rr_exp = '{1, 0, 1, 0, 1, 0};

    for (int k = 0; k < 2; k++) begin
      rst[k]      = 1'b1;
      if_req[k]   = 1'b0;
      if_addr[k]  = '0;
      ls_req[k]   = 1'b0;
      ls_we[k]    = 1'b0;
      ls_be[k]    = '0;
      ls_addr[k]  = '0;
      ls_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    repeat (10) @(negedge clk);
    #1;
    chk_zero(0, "idle0");
    chk_zero(1, "idle1");
    chk("idle_no_grants", gnt_log.size(), 0);

    exp_if.push_back(32'hDEADBEEF);
    if_req[0]  = 1'b1;
    if_addr[0] = 31'h10;
    wait_gnt(0, 1'b0, n, ok);
    chk("if_gnt_cycle", n, 1);
    chk("if_mem_addr", mem_addr[0], 32'h10);
    chk("if_mem_we", mem_we[0], 0);
    chk("if_mem_be", mem_be[0], 4'hF);
    if_req[0] = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    #1;
    chk("if_single_txn", gnt_log.size(), 1);
    gnt_log.delete();

    foreach (tbl[i]) ls_op(0, tbl[i]);

    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    gnt_log.delete();
    for (int i = 0; i < 3; i++) begin
      exp_if.push_back(32'hDEADBEEF);
      exp_ls.push_back(32'hCAFEF00D);
    end
    if_req[0]  = 1'b1;
    if_addr[0] = 31'h10;
    ls_req[0]  = 1'b1;
    ls_we[0]   = 1'b0;
    ls_addr[0] = 31'h21;
    wait_grants(6);
    if_req[0] = 1'b0;
    ls_req[0] = 1'b0;
    chk("rr_count", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      chk($sformatf("rr_order%0d", i), gnt_log[i], rr_exp[i]);
    drain();
    repeat (3) @(negedge clk);
    #1;
    chk("rr_no_extra", gnt_log.size(), 6);

    gnt_log.delete();
    gnt_time.delete();
    exp_if.push_back(32'hDEADBEEF);
    exp_if.push_back(32'hDEADBEEF);
    if_req[1]  = 1'b1;
    if_addr[1] = 31'h10;
    wait_grants(2);
    if_req[1] = 1'b0;
    chk("lat3_count", gnt_time.size(), 2);
    if (gnt_time.size() >= 2)
      chk("lat3_spacing", gnt_time[1] - gnt_time[0], 5);
    drain();

    gnt_log.delete();
    ls_req[1]  = 1'b1;
    ls_we[1]   = 1'b0;
    ls_addr[1] = 31'h10;
    wait_gnt(1, 1'b1, n, ok);
    ls_req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk_zero(1, "rst_wait");
    if_req[1]  = 1'b1;
    if_addr[1] = 31'h10;
    ls_req[1]  = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk_zero(1, "rst_hold");
    gnt_log.delete();
    rst[1] = 1'b0;
    exp_ls.push_back(32'hDEADBEEF);
    exp_if.push_back(32'hDEADBEEF);
    wait_grants(2);
    if_req[1] = 1'b0;
    ls_req[1] = 1'b0;
    chk("post_rst_count", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      chk("post_rst_first_ls", gnt_log[0], 1);
      chk("post_rst_second_if", gnt_log[1], 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
